axi4_lite_fanin: RTL and testbench
==================================

AXI4_LITE_FANIN -- requirements
Module: axi4_lite_fanin

Interface
REQ-001 Parameter A, default 16, address width in bits.
REQ-002 Parameter N, default 4, data width in bytes; data bus is N*8 bits.
REQ-003 Parameter I, default 1, ID width; IDs pass through unchanged.
REQ-004 aclk  input  1  single clock; all logic on rising edge.
REQ-005 areset  input  1  reset, synchronous and active-high.
REQ-006 axi4_s[2]  slave  axi4_if #(A,N)  upstream AXI4-Lite masters; port 0 and port 1.
REQ-007 axi4_m  master  axi4_if #(A,N)  single downstream AXI4-Lite port; feeds axi4_lite_fanout.

Function
REQ-008 Write path and read path SHALL each have an independent two-way arbiter and FSM.
REQ-009 Write FSM states:
- W_IDLE: arbitrate on awvalid.
- W_ADDR: forward AW and W from the granted port; stay until both handshakes complete, in either order or the same cycle.
- W_RESP: route bvalid/bresp to the granted port; return to W_IDLE on the granted bready.
REQ-010 Read FSM states:
- R_IDLE: arbitrate on arvalid.
- R_ADDR: forward AR from the granted port; on arready go to R_DATA.
- R_DATA: route rvalid/rdata/rresp to the granted port; return to R_IDLE on the granted rready.
REQ-011 Grant is registered: a request sampled in IDLE SHALL be forwarded on axi4_m no earlier than the next cycle (1-cycle arbitration latency).
REQ-012 Each FSM SHALL allow at most one outstanding transaction; the grant is held until the response handshake completes.
REQ-013 The non-granted port SHALL see awready, wready, arready, bvalid and rvalid held at 0.
REQ-014 With RR enabled and both ports requesting in the same IDLE cycle, the port not granted last SHALL win; the last-grant pointer updates only on grant.
REQ-015 A single requester SHALL be granted immediately, regardless of the pointer.
REQ-016 Response data and resp codes SHALL pass through unmodified; no buffering beyond grant and state registers.
REQ-017 A write and a read MAY proceed concurrently, including from different ports.

Reset
REQ-018 On areset, both FSMs go to IDLE and both last-grant pointers are set to port 1, so port 0 wins the first tie.
REQ-019 During reset and in the following IDLE cycle, all axi4_m valids and all axi4_s readies/valids SHALL be 0.
REQ-020 Reset mid-transaction SHALL abandon the transaction without emitting a response.

Configuration
REQ-021 Macro AXI4_LITE_FANIN_RR_EN:
- Defined: round-robin tie-break per REQ-014.
- Undefined: fixed priority, port 0 always wins ties; pointer logic removed.

Structure
REQ-022 Package axi4_lite_fanin_pkg SHALL hold the write-state and read-state enum typedefs and the port-count constant (2).
REQ-023 Sub-module axi4_lite_fanin_arb (two-request arbiter, registered grant and pointer, honours REQ-021) SHALL be instanced once for write and once for read.

Verification
REQ-024 Port 0 writes 'habba_beef to 'h0004, then reads 'h0004 -> bresp OKAY to port 0; rdata 'habba_beef; port 1 sees no valids.
REQ-025 Both ports assert arvalid in the same cycle for 'h0004 and 'h0104 (RR enabled, after reset) -> port 0 served first, then port 1; a repeated tie serves port 1 first.
REQ-026 Port 0 write to 'h0008 concurrent with port 1 read of 'h0108 -> both complete with OKAY; the read returns the register_file value.
REQ-027 Downstream bready stall: port 0 holds bready low for 5 cycles -> bvalid held, no new write grant; port 1 awvalid waits, then completes.
REQ-028 areset asserted in W_ADDR after AW and before W -> next cycle FSM idle, all valids 0; a subsequent port 1 write completes normally.
REQ-029 Without AXI4_LITE_FANIN_RR_EN, 4 back-to-back read ties -> port 0 granted all 4 times.

Source files
------------

// File: rtl/axi4_lite_fanin_pkg.sv
// Shared types for the two-port AXI4-Lite fan-in: FSM state encodings and port count.
package axi4_lite_fanin_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } r_state_t;

endpackage

// File: rtl/axi4_lite_fanin_if.sv
// AXI4-Lite bus bundle (axi4_if) with master/slave views; IDs ride along for pass-through.
interface axi4_if #(
  parameter int A = 16,
  parameter int N = 4,
  parameter int I = 1
) ();
  logic           awvalid;
  logic           awready;
  logic [A-1:0]   awaddr;
  logic [I-1:0]   awid;
  logic           wvalid;
  logic           wready;
  logic [8*N-1:0] wdata;
  logic [N-1:0]   wstrb;
  logic           bvalid;
  logic           bready;
  logic [1:0]     bresp;
  logic [I-1:0]   bid;
  logic           arvalid;
  logic           arready;
  logic [A-1:0]   araddr;
  logic [I-1:0]   arid;
  logic           rvalid;
  logic           rready;
  logic [8*N-1:0] rdata;
  logic [1:0]     rresp;
  logic [I-1:0]   rid;

  modport master (
    output awvalid, awaddr, awid, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arid, rready,
    input  awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rid
  );

  modport slave (
    input  awvalid, awaddr, awid, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arid, rready,
    output awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rid
  );
endinterface

// File: rtl/axi4_lite_fanin_arb.sv
// Two-request arbiter with registered grant. AXI4_LITE_FANIN_RR_EN selects round-robin
// tie-break; otherwise port 0 wins every tie.
module axi4_lite_fanin_arb
  import axi4_lite_fanin_pkg::*;
(
  input  logic                 clk,
  input  logic                 srst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 take,
  output logic                 gnt
);

  logic gnt_reg;
  logic pick;

`ifdef AXI4_LITE_FANIN_RR_EN
  logic last_reg;

  // A lone requester wins outright; a tie goes to the port not granted last.
  always_comb pick = (&req) ? ~last_reg : req[1];

  always_ff @(posedge clk) begin
    if (srst) begin
      last_reg <= 1'b1;
    end else if (take) begin
      last_reg <= pick;
    end
  end
`else
  always_comb pick = req[1] & ~req[0];
`endif

  always_ff @(posedge clk) begin
    if (srst) begin
      gnt_reg <= 1'b0;
    end else if (take) begin
      gnt_reg <= pick;
    end
  end

  assign gnt = gnt_reg;

endmodule

// File: rtl/axi4_lite_fanin.sv
// Two upstream AXI4-Lite masters onto one downstream port; independent write and read
// arbiters/FSMs, one outstanding transaction each. Option: AXI4_LITE_FANIN_RR_EN.
module axi4_lite_fanin
  import axi4_lite_fanin_pkg::*;
#(
  parameter int A = 16,
  parameter int N = 4,
  parameter int I = 1
) (
  input  logic   aclk,
  input  logic   areset,
  axi4_if.slave  axi4_s [NUM_PORTS],
  axi4_if.master axi4_m
);

  logic [NUM_PORTS-1:0] s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [A-1:0]         s_awaddr [NUM_PORTS];
  logic [A-1:0]         s_araddr [NUM_PORTS];
  logic [I-1:0]         s_awid   [NUM_PORTS];
  logic [I-1:0]         s_arid   [NUM_PORTS];
  logic [8*N-1:0]       s_wdata  [NUM_PORTS];
  logic [N-1:0]         s_wstrb  [NUM_PORTS];

  w_state_t w_state_reg, w_state_next;
  r_state_t r_state_reg, r_state_next;
  logic     aw_done_reg, aw_done_next;
  logic     w_done_reg, w_done_next;
  logic     w_take, r_take;
  logic     w_gnt, r_gnt;
  logic     aw_fire, w_fire;

  axi4_lite_fanin_arb u_w_arb (
    .clk (aclk), .srst(areset), .req(s_awvalid), .take(w_take), .gnt(w_gnt)
  );

  axi4_lite_fanin_arb u_r_arb (
    .clk (aclk), .srst(areset), .req(s_arvalid), .take(r_take), .gnt(r_gnt)
  );

  // Downstream side: only the granted port's channels are forwarded.
  assign axi4_m.awvalid = (w_state_reg == W_ADDR) && !aw_done_reg && s_awvalid[w_gnt];
  assign axi4_m.awaddr  = s_awaddr[w_gnt];
  assign axi4_m.awid    = s_awid[w_gnt];
  assign axi4_m.wvalid  = (w_state_reg == W_ADDR) && !w_done_reg && s_wvalid[w_gnt];
  assign axi4_m.wdata   = s_wdata[w_gnt];
  assign axi4_m.wstrb   = s_wstrb[w_gnt];
  assign axi4_m.bready  = (w_state_reg == W_RESP) && s_bready[w_gnt];
  assign axi4_m.arvalid = (r_state_reg == R_ADDR) && s_arvalid[r_gnt];
  assign axi4_m.araddr  = s_araddr[r_gnt];
  assign axi4_m.arid    = s_arid[r_gnt];
  assign axi4_m.rready  = (r_state_reg == R_DATA) && s_rready[r_gnt];

  assign aw_fire = axi4_m.awvalid && axi4_m.awready;
  assign w_fire  = axi4_m.wvalid && axi4_m.wready;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign s_awvalid[gi] = axi4_s[gi].awvalid;
      assign s_awaddr[gi]  = axi4_s[gi].awaddr;
      assign s_awid[gi]    = axi4_s[gi].awid;
      assign s_wvalid[gi]  = axi4_s[gi].wvalid;
      assign s_wdata[gi]   = axi4_s[gi].wdata;
      assign s_wstrb[gi]   = axi4_s[gi].wstrb;
      assign s_bready[gi]  = axi4_s[gi].bready;
      assign s_arvalid[gi] = axi4_s[gi].arvalid;
      assign s_araddr[gi]  = axi4_s[gi].araddr;
      assign s_arid[gi]    = axi4_s[gi].arid;
      assign s_rready[gi]  = axi4_s[gi].rready;

      // Readies and valids are gated per port; payloads are broadcast unmodified.
      assign axi4_s[gi].awready = (w_state_reg == W_ADDR) && !aw_done_reg &&
                                  (w_gnt == 1'(gi)) && axi4_m.awready;
      assign axi4_s[gi].wready  = (w_state_reg == W_ADDR) && !w_done_reg &&
                                  (w_gnt == 1'(gi)) && axi4_m.wready;
      assign axi4_s[gi].bvalid  = (w_state_reg == W_RESP) && (w_gnt == 1'(gi)) &&
                                  axi4_m.bvalid;
      assign axi4_s[gi].bresp   = axi4_m.bresp;
      assign axi4_s[gi].bid     = axi4_m.bid;
      assign axi4_s[gi].arready = (r_state_reg == R_ADDR) && (r_gnt == 1'(gi)) &&
                                  axi4_m.arready;
      assign axi4_s[gi].rvalid  = (r_state_reg == R_DATA) && (r_gnt == 1'(gi)) &&
                                  axi4_m.rvalid;
      assign axi4_s[gi].rdata   = axi4_m.rdata;
      assign axi4_s[gi].rresp   = axi4_m.rresp;
      assign axi4_s[gi].rid     = axi4_m.rid;
    end
  endgenerate

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_reg <= W_IDLE;
      r_state_reg <= R_IDLE;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      w_state_reg <= w_state_next;
      r_state_reg <= r_state_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = w_state_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    w_take       = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        if (|s_awvalid) begin
          w_take       = 1'b1;
          w_state_next = W_ADDR;
        end
      end
      W_ADDR: begin
        // AW and W may complete in either order or together.
        if ((aw_done_reg || aw_fire) && (w_done_reg || w_fire)) begin
          w_state_next = W_RESP;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
        end else begin
          aw_done_next = aw_done_reg || aw_fire;
          w_done_next  = w_done_reg || w_fire;
        end
      end
      W_RESP: begin
        if (axi4_m.bvalid && axi4_m.bready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_next = r_state_reg;
    r_take       = 1'b0;
    case (r_state_reg)
      R_IDLE: begin
        if (|s_arvalid) begin
          r_take       = 1'b1;
          r_state_next = R_ADDR;
        end
      end
      R_ADDR: begin
        if (axi4_m.arvalid && axi4_m.arready) r_state_next = R_DATA;
      end
      R_DATA: begin
        if (axi4_m.rvalid && axi4_m.rready) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_lite_fanin.sv
// Directed bench for axi4_lite_fanin: two upstream masters, a register-file responder downstream.
module tb_axi4_lite_fanin;

  localparam int A = 16;
  localparam int N = 4;
  localparam int I = 1;
`ifdef AXI4_LITE_FANIN_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int evals = 0;
  int fails = 0;

  axi4_if #(.A(A), .N(N), .I(I)) s_if [2] ();
  axi4_if #(.A(A), .N(N), .I(I)) m_if ();

  axi4_lite_fanin #(.A(A), .N(N), .I(I)) dut (
    .aclk  (aclk),
    .areset(areset),
    .axi4_s(s_if),
    .axi4_m(m_if)
  );

  logic [1:0]   tb_awvalid, tb_wvalid, tb_bready, tb_arvalid, tb_rready;
  logic [A-1:0] tb_awaddr [2];
  logic [A-1:0] tb_araddr [2];
  logic [31:0]  tb_wdata  [2];
  logic [1:0]   tb_awready, tb_wready, tb_bvalid, tb_arready, tb_rvalid;
  logic [1:0]   tb_bresp  [2];
  logic [1:0]   tb_rresp  [2];
  logic [31:0]  tb_rdata  [2];
  logic [I-1:0] tb_bid    [2];
  logic [I-1:0] tb_rid    [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_up
      assign s_if[gi].awvalid = tb_awvalid[gi];
      assign s_if[gi].awaddr  = tb_awaddr[gi];
      assign s_if[gi].awid    = 1'b1;
      assign s_if[gi].wvalid  = tb_wvalid[gi];
      assign s_if[gi].wdata   = tb_wdata[gi];
      assign s_if[gi].wstrb   = 4'hF;
      assign s_if[gi].bready  = tb_bready[gi];
      assign s_if[gi].arvalid = tb_arvalid[gi];
      assign s_if[gi].araddr  = tb_araddr[gi];
      assign s_if[gi].arid    = 1'b1;
      assign s_if[gi].rready  = tb_rready[gi];
      assign tb_awready[gi]   = s_if[gi].awready;
      assign tb_wready[gi]    = s_if[gi].wready;
      assign tb_bvalid[gi]    = s_if[gi].bvalid;
      assign tb_bresp[gi]     = s_if[gi].bresp;
      assign tb_bid[gi]       = s_if[gi].bid;
      assign tb_arready[gi]   = s_if[gi].arready;
      assign tb_rvalid[gi]    = s_if[gi].rvalid;
      assign tb_rdata[gi]     = s_if[gi].rdata;
      assign tb_rresp[gi]     = s_if[gi].rresp;
      assign tb_rid[gi]       = s_if[gi].rid;
    end
  endgenerate

  // Downstream register file: unwritten words read back as 32'hC0DE_0000 | address.
  logic         s_aw_got, s_w_got, s_bvalid, s_rvalid;
  logic [A-1:0] s_awaddr_q;
  logic [31:0]  s_wdata_q, s_rdata;
  logic [I-1:0] s_awid_q, s_bid, s_rid;
  logic [31:0]  mem [256];
  logic [255:0] wr_flag;
  wire          aw_hs = m_if.awvalid & m_if.awready;
  wire          w_hs  = m_if.wvalid & m_if.wready;
  wire          ar_hs = m_if.arvalid & m_if.arready;
  wire [A-1:0]  wa    = aw_hs ? m_if.awaddr : s_awaddr_q;
  wire [31:0]   wd    = w_hs ? m_if.wdata : s_wdata_q;

  assign m_if.awready = !s_bvalid && !s_aw_got;
  assign m_if.wready  = !s_bvalid && !s_w_got;
  assign m_if.bvalid  = s_bvalid;
  assign m_if.bresp   = 2'b00;
  assign m_if.bid     = s_bid;
  assign m_if.arready = !s_rvalid;
  assign m_if.rvalid  = s_rvalid;
  assign m_if.rdata   = s_rdata;
  assign m_if.rresp   = 2'b00;
  assign m_if.rid     = s_rid;

  always @(posedge aclk) begin
    if (areset) begin
      s_aw_got <= 1'b0;
      s_w_got  <= 1'b0;
      s_bvalid <= 1'b0;
      s_rvalid <= 1'b0;
      wr_flag  <= '0;
    end else begin
      if (aw_hs) begin
        s_aw_got   <= 1'b1;
        s_awaddr_q <= m_if.awaddr;
        s_awid_q   <= m_if.awid;
      end
      if (w_hs) begin
        s_w_got   <= 1'b1;
        s_wdata_q <= m_if.wdata;
      end
      if ((s_aw_got || aw_hs) && (s_w_got || w_hs)) begin
        s_bvalid        <= 1'b1;
        s_bid           <= aw_hs ? m_if.awid : s_awid_q;
        mem[wa[9:2]]    <= wd;
        wr_flag[wa[9:2]] <= 1'b1;
        s_aw_got        <= 1'b0;
        s_w_got         <= 1'b0;
      end
      if (s_bvalid && m_if.bready) s_bvalid <= 1'b0;
      if (ar_hs) begin
        s_rvalid <= 1'b1;
        s_rid    <= m_if.arid;
        s_rdata  <= wr_flag[m_if.araddr[9:2]] ? mem[m_if.araddr[9:2]]
                                              : (32'hC0DE_0000 | {16'h0, m_if.araddr});
      end else if (s_rvalid && m_if.rready) begin
        s_rvalid <= 1'b0;
      end
    end
  end

  int p1_seen = 0;
  int excl_viol = 0;
  always @(negedge aclk) begin
    if (tb_awready[1] | tb_wready[1] | tb_arready[1] | tb_bvalid[1] | tb_rvalid[1])
      p1_seen <= p1_seen + 1;
    if ((&tb_awready) | (&tb_wready) | (&tb_arready) | (&tb_bvalid) | (&tb_rvalid))
      excl_viol <= excl_viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    evals++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_m"}, {27'd0, m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready}, 32'd0);
    check({tag, "_s"}, {22'd0, tb_awready, tb_wready, tb_arready, tb_bvalid, tb_rvalid}, 32'd0);
  endtask

  task automatic reset_dut();
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    @(posedge aclk); #1;
  endtask

  task automatic do_write(input int p, input logic [A-1:0] addr, input logic [31:0] data,
                          input int stall, output logic [1:0] resp, output logic [I-1:0] id,
                          output int aw_cyc, output int b_cyc, output int stall_hold);
    bit aw_f, w_f, b_f;
    int n;
    resp = 'x; id = 'x; aw_cyc = -1; b_cyc = -1; stall_hold = 0;
    tb_awaddr[p] = addr; tb_wdata[p] = data;
    tb_awvalid[p] = 1'b1; tb_wvalid[p] = 1'b1;
    n = 0;
    while ((tb_awvalid[p] || tb_wvalid[p]) && n < 40) begin
      #1;
      aw_f = tb_awvalid[p] & tb_awready[p];
      w_f  = tb_wvalid[p] & tb_wready[p];
      @(posedge aclk); #1;
      n++;
      if (aw_f) begin tb_awvalid[p] = 1'b0; aw_cyc = cyc; end
      if (w_f) tb_wvalid[p] = 1'b0;
    end
    tb_awvalid[p] = 1'b0; tb_wvalid[p] = 1'b0;
    for (int k = 0; k < stall; k++) begin
      #1;
      if (tb_bvalid[p]) stall_hold++;
      @(posedge aclk); #1;
    end
    tb_bready[p] = 1'b1;
    b_f = 1'b0; n = 0;
    while (!b_f && n < 40) begin
      #1;
      b_f = tb_bvalid[p];
      if (b_f) begin resp = tb_bresp[p]; id = tb_bid[p]; end
      @(posedge aclk); #1;
      n++;
    end
    b_cyc = cyc;
    tb_bready[p] = 1'b0;
    $display("[%0t] WR port%0d addr=%h data=%h bresp=%h aw_cyc=%0d b_cyc=%0d", $time, p, addr, data, resp, aw_cyc, b_cyc);
  endtask

  task automatic do_read(input int p, input logic [A-1:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output logic [I-1:0] id, output int ar_cyc);
    bit ar_f, r_f;
    int n;
    data = 'x; resp = 'x; id = 'x; ar_cyc = -1;
    tb_araddr[p] = addr; tb_arvalid[p] = 1'b1; tb_rready[p] = 1'b1;
    n = 0;
    while (tb_arvalid[p] && n < 40) begin
      #1;
      ar_f = tb_arready[p];
      @(posedge aclk); #1;
      n++;
      if (ar_f) begin tb_arvalid[p] = 1'b0; ar_cyc = cyc; end
    end
    tb_arvalid[p] = 1'b0;
    r_f = 1'b0; n = 0;
    while (!r_f && n < 40) begin
      #1;
      r_f = tb_rvalid[p];
      if (r_f) begin data = tb_rdata[p]; resp = tb_rresp[p]; id = tb_rid[p]; end
      @(posedge aclk); #1;
      n++;
    end
    tb_rready[p] = 1'b0;
    $display("[%0t] RD port%0d addr=%h rdata=%h rresp=%h ar_cyc=%0d", $time, p, addr, data, resp, ar_cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    logic [1:0]   r0, r1, rr0, rr1;
    logic [31:0]  d0, d0b, d1;
    logic [I-1:0] id0, id1;
    int           a0, b0, h0, a1, b1, h1, c0, c0b, c1, p1_before, n;
    bit           aw_f;

    tb_awvalid = '0; tb_wvalid = '0; tb_bready = '0; tb_arvalid = '0; tb_rready = '0;
    for (int k = 0; k < 2; k++) begin
      tb_awaddr[k] = '0; tb_araddr[k] = '0; tb_wdata[k] = '0;
    end

    // Reset state and the first IDLE cycle afterwards.
    repeat (2) @(posedge aclk);
    #1;
    check_quiet("in_reset");
    areset = 1'b0;
    @(posedge aclk); #1;
    check_quiet("idle_after_reset");

    // Port 0 write then read of 0x0004; port 1 must stay silent.
    p1_before = p1_seen;
    do_write(0, 16'h0004, 32'habba_beef, 0, r0, id0, a0, b0, h0);
    check("wr0_bresp", {30'd0, r0}, 32'd0);
    check("wr0_bid", {31'd0, id0}, 32'd1);
    do_read(0, 16'h0004, d0, rr0, id0, c0);
    check("rd0_rdata", d0, 32'habba_beef);
    check("rd0_rresp", {30'd0, rr0}, 32'd0);
    check("rd0_rid", {31'd0, id0}, 32'd1);
    check("p1_silent", p1_seen - p1_before, 32'd0);

    // Read tie after reset, then a repeated tie against the still-waiting port 1.
    reset_dut();
    fork
      begin
        do_read(0, 16'h0004, d0, rr0, id0, c0);
        do_read(0, 16'h0004, d0b, rr0, id0, c0b);
      end
      do_read(1, 16'h0104, d1, rr1, id1, c1);
    join
    check("tie1_port0_first", {31'd0, c0 < c1}, 32'd1);
    check("tie2_port1_first", {31'd0, c1 < c0b}, {31'd0, RR});
    check("tie_rd0_data", d0, 32'hC0DE_0004);
    check("tie_rd1_data", d1, 32'hC0DE_0104);

    // Four back-to-back read ties from a fresh reset.
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      fork
        do_read(0, 16'h0004, d0, rr0, id0, c0);
        do_read(1, 16'h0104, d1, rr1, id1, c1);
      join
      check($sformatf("tie_round%0d_port0", k), {31'd0, c0 < c1}, 32'd1);
    end

    // Concurrent write (port 0) and read (port 1).
    fork
      do_write(0, 16'h0008, 32'h1234_5678, 0, r0, id0, a0, b0, h0);
      do_read(1, 16'h0108, d1, rr1, id1, c1);
    join
    check("conc_bresp", {30'd0, r0}, 32'd0);
    check("conc_rresp", {30'd0, rr1}, 32'd0);
    check("conc_rdata", d1, 32'hC0DE_0108);
    do_read(1, 16'h0008, d1, rr1, id1, c1);
    check("conc_readback", d1, 32'h1234_5678);

    // bready stall on port 0 while port 1 waits for the write channel.
    fork
      do_write(0, 16'h000C, 32'h0C0C_0C0C, 5, r0, id0, a0, b0, h0);
      begin
        @(posedge aclk); #1;
        do_write(1, 16'h010C, 32'h1111_2222, 0, r1, id1, a1, b1, h1);
      end
    join
    check("stall_bvalid_held", h0, 32'd5);
    check("stall_p1_waits", {31'd0, a1 > b0}, 32'd1);
    check("stall_bresp0", {30'd0, r0}, 32'd0);
    check("stall_bresp1", {30'd0, r1}, 32'd0);

    // Reset after AW, before W: transaction dropped, next write normal.
    tb_awaddr[0] = 16'h0010; tb_awvalid[0] = 1'b1;
    aw_f = 1'b0; n = 0;
    while (!aw_f && n < 20) begin
      #1;
      aw_f = tb_awready[0];
      @(posedge aclk); #1;
      n++;
    end
    check("aw_only_hs", {31'd0, aw_f}, 32'd1);
    tb_awvalid[0] = 1'b0;
    areset = 1'b1;
    @(posedge aclk); #1;
    check_quiet("mid_txn_reset");
    areset = 1'b0;
    @(posedge aclk); #1;
    check_quiet("after_mid_reset");
    do_write(1, 16'h0110, 32'hCAFE_F00D, 0, r1, id1, a1, b1, h1);
    check("post_reset_bresp", {30'd0, r1}, 32'd0);
    do_read(1, 16'h0110, d1, rr1, id1, c1);
    check("post_reset_rdata", d1, 32'hCAFE_F00D);

    check("grant_exclusive", excl_viol, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
    $finish;
  end

endmodule
